// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures execute-stage results and control, drives memory stage.
// Optional stall/bubble performance counters when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_register #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_Stall,
    input  logic                  i_Flush,
    input  logic                  i_Valid,
    input  logic                  i_Sig_MemRead,
    input  logic                  i_Sig_MemWrite,
    input  logic                  i_Sig_RegWrite,
    input  logic                  i_Sig_MemToReg,
    input  logic [DATA_W-1:0]     i_ALU_Result,
    input  logic [DATA_W-1:0]     i_Write_Data,
    input  logic [REG_ADDR_W-1:0] i_Rd,
    output logic                  o_Valid,
    output logic                  o_Sig_MemRead,
    output logic                  o_Sig_MemWrite,
    output logic                  o_Sig_RegWrite,
    output logic                  o_Sig_MemToReg,
    output logic [DATA_W-1:0]     o_Address,
    output logic [DATA_W-1:0]     o_Write_Data,
    output logic [REG_ADDR_W-1:0] o_Rd,
    output logic                  o_Fwd_Valid,
    output logic                  o_Load_Pending,
    output logic                  o_Ctrl_Err
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [15:0]           o_Stall_Cnt,
    output logic [15:0]           o_Bubble_Cnt
`endif
);

    logic                  valid_q, valid_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  ctrl_err_q, ctrl_err_d;

    always_comb begin
        valid_d      = valid_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        ctrl_err_d   = 1'b0;
        if (i_Flush) begin
            valid_d      = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!i_Stall) begin
            valid_d      = i_Valid;
            mem_read_d   = i_Sig_MemRead;
            mem_write_d  = i_Sig_MemWrite;
            reg_write_d  = i_Sig_RegWrite & (i_Rd != '0);
            mem_to_reg_d = i_Sig_MemToReg;
            addr_d       = i_ALU_Result;
            wdata_d      = i_Write_Data;
            rd_d         = i_Rd;
            // Conflicting load+store resolves to the store so memory is never read and written at once.
            if (i_Valid && i_Sig_MemRead && i_Sig_MemWrite) begin
                mem_read_d   = 1'b0;
                mem_to_reg_d = 1'b0;
                ctrl_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            ctrl_err_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            ctrl_err_q   <= ctrl_err_d;
        end
    end

    assign o_Valid        = valid_q;
    assign o_Sig_MemRead  = valid_q & mem_read_q;
    assign o_Sig_MemWrite = valid_q & mem_write_q;
    assign o_Sig_RegWrite = valid_q & reg_write_q;
    assign o_Sig_MemToReg = valid_q & mem_to_reg_q;
    assign o_Address      = addr_q;
    assign o_Write_Data   = wdata_q;
    assign o_Rd           = rd_q;
    assign o_Fwd_Valid    = valid_q & reg_write_q & ~mem_read_q;
    assign o_Load_Pending = valid_q & mem_read_q & (rd_q != '0);
    assign o_Ctrl_Err     = ctrl_err_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    // A bubble is any edge that loads valid as 0: flush, or an unstalled load of an empty slot.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (i_Stall && !i_Flush && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if ((i_Flush || (!i_Stall && !i_Valid)) && bubble_cnt_q != 16'hFFFF)
            bubble_cnt_d = bubble_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= 16'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign o_Stall_Cnt  = stall_cnt_q;
    assign o_Bubble_Cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// Scoreboard bench for ex_mem_register: directed cases then randomized traffic vs a reference model.
// Exercises the perf counters as well when EX_MEM_PERF_CNT_EN is defined.
module tb_ex_mem_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_Stall, i_Flush, i_Valid;
    logic        i_Sig_MemRead, i_Sig_MemWrite, i_Sig_RegWrite, i_Sig_MemToReg;
    logic [15:0] i_ALU_Result, i_Write_Data;
    logic [2:0]  i_Rd;
    logic        o_Valid, o_Sig_MemRead, o_Sig_MemWrite, o_Sig_RegWrite, o_Sig_MemToReg;
    logic [15:0] o_Address, o_Write_Data;
    logic [2:0]  o_Rd;
    logic        o_Fwd_Valid, o_Load_Pending, o_Ctrl_Err;
`ifdef EX_MEM_PERF_CNT_EN
    logic [15:0] o_Stall_Cnt, o_Bubble_Cnt;
`endif

    always #5 clk = ~clk;

    ex_mem_register dut (
        .clk(clk), .rst_n(rst_n), .i_Stall(i_Stall), .i_Flush(i_Flush), .i_Valid(i_Valid),
        .i_Sig_MemRead(i_Sig_MemRead), .i_Sig_MemWrite(i_Sig_MemWrite),
        .i_Sig_RegWrite(i_Sig_RegWrite), .i_Sig_MemToReg(i_Sig_MemToReg),
        .i_ALU_Result(i_ALU_Result), .i_Write_Data(i_Write_Data), .i_Rd(i_Rd),
        .o_Valid(o_Valid), .o_Sig_MemRead(o_Sig_MemRead), .o_Sig_MemWrite(o_Sig_MemWrite),
        .o_Sig_RegWrite(o_Sig_RegWrite), .o_Sig_MemToReg(o_Sig_MemToReg),
        .o_Address(o_Address), .o_Write_Data(o_Write_Data), .o_Rd(o_Rd),
        .o_Fwd_Valid(o_Fwd_Valid), .o_Load_Pending(o_Load_Pending), .o_Ctrl_Err(o_Ctrl_Err)
`ifdef EX_MEM_PERF_CNT_EN
        , .o_Stall_Cnt(o_Stall_Cnt), .o_Bubble_Cnt(o_Bubble_Cnt)
`endif
    );

    typedef struct {
        logic        valid, rd_en, wr_en, rw_en, m2r, fwd, lp, err;
        logic [15:0] addr, wdata;
        logic [2:0]  rd;
        logic [15:0] stall_cnt, bubble_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference view of the instruction sitting in MEM
    typedef enum {K_NONE, K_LOAD, K_STORE, K_ALU} kind_e;
    kind_e       m_kind;
    logic        m_valid, m_regwr, m_m2r, m_err;
    logic [15:0] m_addr, m_wdata;
    logic [2:0]  m_rd;
    int          m_stall_cnt, m_bubble_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_kind = K_NONE; m_regwr = 0; m_m2r = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_rd = 0; m_stall_cnt = 0; m_bubble_cnt = 0;
    endtask

    // Drive one cycle of inputs (at a negedge), advance the model, queue the expected outputs.
    task automatic step(input logic st, input logic fl, input logic v, input logic mr,
                        input logic mw, input logic rw, input logic m2r,
                        input logic [15:0] alu, input logic [15:0] wd, input logic [2:0] rd);
        exp_t e;
        i_Stall = st; i_Flush = fl; i_Valid = v; i_Sig_MemRead = mr; i_Sig_MemWrite = mw;
        i_Sig_RegWrite = rw; i_Sig_MemToReg = m2r; i_ALU_Result = alu; i_Write_Data = wd; i_Rd = rd;
        if (fl) begin
            m_valid = 0; m_kind = K_NONE; m_regwr = 0; m_m2r = 0; m_err = 0;
            m_bubble_cnt = (m_bubble_cnt < 65535) ? m_bubble_cnt + 1 : 65535;
        end else if (st) begin
            m_err = 0;
            m_stall_cnt = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : 65535;
        end else begin
            m_valid = v;
            m_err   = v && mr && mw;
            m_kind  = mw ? K_STORE : (mr ? K_LOAD : K_ALU);
            m_regwr = rw && (rd != 0);
            m_m2r   = m_err ? 1'b0 : m2r;
            m_addr = alu; m_wdata = wd; m_rd = rd;
            if (!v) m_bubble_cnt = (m_bubble_cnt < 65535) ? m_bubble_cnt + 1 : 65535;
        end
        e.valid = m_valid;
        e.rd_en = m_valid && m_kind == K_LOAD;
        e.wr_en = m_valid && m_kind == K_STORE;
        e.rw_en = m_valid && m_regwr;
        e.m2r   = m_valid && m_m2r;
        e.fwd   = m_valid && m_regwr && m_kind != K_LOAD;
        e.lp    = m_valid && m_kind == K_LOAD && m_rd != 0;
        e.err   = m_err;
        e.addr = m_addr; e.wdata = m_wdata; e.rd = m_rd;
        e.stall_cnt = 16'(m_stall_cnt); e.bubble_cnt = 16'(m_bubble_cnt);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_out"}, {o_Valid, o_Sig_MemRead, o_Sig_MemWrite, o_Sig_RegWrite, o_Sig_MemToReg,
                           o_Fwd_Valid, o_Load_Pending, o_Ctrl_Err}, 0);
        chk({nm, "_data"}, {o_Address, o_Write_Data}, 0);
        chk({nm, "_rd"}, o_Rd, 0);
    endtask

    // Monitor: the stage presents a fresh result after every edge while out of reset
    always @(posedge clk) begin
        #1;
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("valid", o_Valid, e.valid);
            chk("memread", o_Sig_MemRead, e.rd_en);
            chk("memwrite", o_Sig_MemWrite, e.wr_en);
            chk("regwrite", o_Sig_RegWrite, e.rw_en);
            chk("memtoreg", o_Sig_MemToReg, e.m2r);
            chk("fwd_valid", o_Fwd_Valid, e.fwd);
            chk("load_pending", o_Load_Pending, e.lp);
            chk("ctrl_err", o_Ctrl_Err, e.err);
            if (e.valid) begin
                chk("address", o_Address, e.addr);
                chk("write_data", o_Write_Data, e.wdata);
                chk("rd", o_Rd, e.rd);
            end
`ifdef EX_MEM_PERF_CNT_EN
            chk("stall_cnt", o_Stall_Cnt, e.stall_cnt);
            chk("bubble_cnt", o_Bubble_Cnt, e.bubble_cnt);
`endif
        end
    end

    initial begin
        rst_n = 0;
        step_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Store: address 0040, data BEEF
        step(0, 0, 1, 0, 1, 0, 0, 16'h0040, 16'hBEEF, 3'd2);
        // Stall 3 cycles with different inputs applied, then resume
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 1, 1, 16'h1111 * 16'(i + 1), 16'h2222, 3'd4);
        step(0, 0, 1, 0, 0, 1, 0, 16'h0123, 16'h4567, 3'd6);
        // Flush and stall on the same edge with a valid load to r5
        step(1, 1, 1, 1, 0, 1, 1, 16'h0050, 16'h0000, 3'd5);
        // Loads to r3 and r0, then an ALU write to r0
        step(0, 0, 1, 1, 0, 1, 1, 16'h0060, 16'h0000, 3'd3);
        step(0, 0, 1, 1, 0, 1, 1, 16'h0064, 16'h0000, 3'd0);
        step(0, 0, 1, 0, 0, 1, 0, 16'h0068, 16'h0000, 3'd0);
        // Conflicting read+write, followed by a normal ALU op so the error pulse must drop
        step(0, 0, 1, 1, 1, 1, 1, 16'h0070, 16'hCAFE, 3'd1);
        step(0, 0, 1, 0, 0, 1, 0, 16'h0074, 16'h0001, 3'd7);
        // Conflict with i_Valid=0 must not raise the error
        step(0, 0, 0, 1, 1, 1, 1, 16'h0078, 16'h0002, 3'd1);

        // Async reset mid-cycle while a valid store is held under stall
        step(0, 0, 1, 0, 1, 0, 0, 16'h0080, 16'hBEEF, 3'd2);
        step(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 3'd0);
        #2 rst_n = 0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #1 chk_all_zero("reset_during_stall");
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 1) == 1, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
        end

`ifdef EX_MEM_PERF_CNT_EN
        for (int i = 0; i < 70000; i++) step(1, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0, 3'd0);
        @(posedge clk);
        #2 chk("stall_cnt_saturated", o_Stall_Cnt, 16'hFFFF);
`else
        @(posedge clk);
        #2;
`endif
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic step_idle();
        i_Stall = 0; i_Flush = 0; i_Valid = 0; i_Sig_MemRead = 0; i_Sig_MemWrite = 0;
        i_Sig_RegWrite = 0; i_Sig_MemToReg = 0; i_ALU_Result = 0; i_Write_Data = 0; i_Rd = 0;
    endtask

endmodule
